memory_mapper: RTL and testbench

Parametrised paging unit that replaces the fixed 48K decode with 128K-style RAM/ROM banking plus a DivMMC automapper. It snoops the Z80 bus, holds the 0x7FFD and 0xE3 paging registers, and turns each CPU address into an external SRAM address, ROM selects and a write gate. It sits between the CPU core and the external SRAM, ROM and VRAM instances in the top level.

---
 rtl/memory_pkg.sv | 32 +++
 rtl/divmmc_automap.sv | 77 +++++++
 rtl/memory_mapper.sv | 140 ++++++++++++++
 tb/tb_memory_mapper.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared constants and types for the 128K/DivMMC paging unit: port decodes,
// automap trap addresses, SRAM region prefixes and the automap state encoding.
package memory_pkg;

   localparam logic [15:0] PORT_7FFD_MASK = 16'h8002;
   localparam logic [7:0]  PORT_E3        = 8'hE3;

   localparam logic [12:0] EXIT_PREFIX    = 13'h03FF;  // 0x1FF8-0x1FFF
   localparam logic [7:0]  INSTANT_PAGE   = 8'h3D;     // 0x3D00-0x3DFF

   localparam logic [1:0]  REGION_SPECTRUM = 2'b00;
   localparam logic [1:0]  REGION_DIV      = 2'b10;

   localparam logic [2:0]  BANK_4000   = 3'd5;
   localparam logic [2:0]  BANK_8000   = 3'd2;
   localparam logic [3:0]  MAPRAM_PAGE = 4'd3;

   typedef enum logic [1:0] {
      AM_IDLE,
      AM_PEND_MAP,
      AM_MAPPED,
      AM_PEND_UNMAP
   } automapState_t;

   function automatic logic isEntryPoint(input logic [15:0] addr);
      case (addr)
         16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/divmmc_automap.sv
// DivMMC automapper: traps opcode fetches at entry/exit points and maps the
// overlay in or out once the fetch completes. Built only with DIVMMC_EN.
`ifdef DIVMMC_EN
module divmmc_automap
   import memory_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        cpuCe,
   input  logic        cpuM1,
   input  logic        cpuMreq,
   input  logic [15:0] cpuA,
   output logic        automapped
);

   automapState_t state;
   logic m1Prev;
   logic cancel;

   logic fetch;
   logic m1Rise;
   logic hitEntry;
   logic hitInstant;
   logic hitExit;

   assign fetch      = !cpuM1 && !cpuMreq;
   assign m1Rise     = cpuM1 && !m1Prev;
   assign hitEntry   = fetch && isEntryPoint(cpuA);
   assign hitInstant = fetch && (cpuA[15:8] == INSTANT_PAGE);
   assign hitExit    = fetch && (cpuA[15:3] == EXIT_PREFIX);

   // cancel remembers an exit trap seen while a map is still pending
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= AM_IDLE;
         m1Prev     <= 1'b1;
         cancel     <= 1'b0;
         automapped <= 1'b0;
      end else if (cpuCe) begin
         m1Prev <= cpuM1;
         case (state)
            AM_IDLE: begin
               if (hitInstant) begin
                  state      <= AM_MAPPED;
                  automapped <= 1'b1;
               end else if (hitEntry) begin
                  state  <= AM_PEND_MAP;
                  cancel <= 1'b0;
               end
            end
            AM_PEND_MAP: begin
               if (m1Rise) begin
                  state      <= cancel ? AM_IDLE : AM_MAPPED;
                  automapped <= !cancel;
               end else if (hitExit) begin
                  cancel <= 1'b1;
               end
            end
            AM_MAPPED: begin
               if (hitExit) state <= AM_PEND_UNMAP;
            end
            AM_PEND_UNMAP: begin
               if (m1Rise) begin
                  state      <= AM_IDLE;
                  automapped <= 1'b0;
               end
            end
            default: begin
               state      <= AM_IDLE;
               automapped <= 1'b0;
            end
         endcase
      end
   end

endmodule
`endif

// File: rtl/memory_mapper.sv
// 128K-style RAM/ROM paging via port 0x7FFD plus an optional DivMMC overlay
// (port 0xE3 and automapper), enabled by defining DIVMMC_EN.
module memory_mapper
   import memory_pkg::*;
#(
   parameter int unsigned RAMBANKS = 8,
   parameter int unsigned DIVPAGES = 16,
   parameter int unsigned AW       = 21
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cpuCe,
   input  logic          cpuM1,
   input  logic          cpuMreq,
   input  logic          cpuIorq,
   input  logic          cpuWr,
   input  logic [7:0]    cpuDi,
   input  logic [15:0]   cpuA,
   output logic          romPage,
   output logic          romCs,
   output logic          divRomCs,
   output logic          divMap,
   output logic          vmmPage,
   output logic          ramWe,
   output logic [AW-1:0] ramA
);

   localparam int unsigned BW  = $clog2(RAMBANKS);
   localparam int unsigned DPW = $clog2(DIVPAGES);
   localparam logic [2:0] BANK_MASK = 3'((32'd1 << BW) - 32'd1);
   localparam logic [3:0] DIV_MASK  = 4'((32'd1 << DPW) - 32'd1);

   logic       portWr;
   logic       sel7ffd;
   logic [2:0] bankHigh;
   logic       vmmReg;
   logic       romReg;
   logic       locked;
   logic [2:0] bank;

   assign portWr  = !cpuIorq && !cpuWr;
   assign sel7ffd = portWr && ((cpuA & PORT_7FFD_MASK) == 16'h0000);

   // 0x7FFD paging register; the lock bit freezes it until reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bankHigh <= 3'd0;
         vmmReg   <= 1'b0;
         romReg   <= 1'b0;
         locked   <= 1'b0;
      end else if (cpuCe && sel7ffd && !locked) begin
         bankHigh <= cpuDi[2:0];
         vmmReg   <= cpuDi[3];
         romReg   <= cpuDi[4];
         locked   <= cpuDi[5];
      end
   end

   assign romPage = romReg;
   assign vmmPage = vmmReg;

`ifdef DIVMMC_EN
   logic       selE3;
   logic       conmem;
   logic       mapram;
   logic [3:0] divPage;
   logic [3:0] divPageM;
   logic       automapped;

   assign selE3    = portWr && (cpuA[7:0] == PORT_E3);
   assign divPageM = divPage & DIV_MASK;

   // 0xE3 control register; mapram can only be set until the next reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         conmem  <= 1'b0;
         mapram  <= 1'b0;
         divPage <= 4'd0;
      end else if (cpuCe && selE3) begin
         conmem  <= cpuDi[7];
         mapram  <= mapram | cpuDi[6];
         divPage <= cpuDi[3:0];
      end
   end

   divmmc_automap uAutomap (
      .clock      (clock),
      .reset      (reset),
      .cpuCe      (cpuCe),
      .cpuM1      (cpuM1),
      .cpuMreq    (cpuMreq),
      .cpuA       (cpuA),
      .automapped (automapped)
   );

   assign divMap = conmem | automapped;
`else
   logic unused;
   assign unused = &{1'b0, cpuM1, cpuMreq, cpuDi[7:6], DIV_MASK};
   assign divMap = 1'b0;
`endif

   always_comb begin
      case (cpuA[15:14])
         2'b01:   bank = BANK_4000;
         2'b10:   bank = BANK_8000;
         2'b11:   bank = bankHigh;
         default: bank = 3'd0;
      endcase
   end

   // Address translation and write gating, zero latency from cpuA
   always_comb begin
      romCs    = 1'b0;
      divRomCs = 1'b0;
      ramWe    = cpuWr;
      ramA     = AW'({REGION_SPECTRUM, bank & BANK_MASK, cpuA[13:0]});
      if (cpuA[15:14] == 2'b00) begin
`ifdef DIVMMC_EN
         if (divMap) begin
            if (!cpuA[13]) begin
               ramWe = 1'b1;
               if (conmem || !mapram) divRomCs = 1'b1;
               else ramA = AW'({REGION_DIV, MAPRAM_PAGE & DIV_MASK, cpuA[12:0]});
            end else begin
               ramA = AW'({REGION_DIV, divPageM, cpuA[12:0]});
               if (mapram && !conmem && (divPageM == MAPRAM_PAGE)) ramWe = 1'b1;
            end
         end else begin
            romCs = 1'b1;
            ramWe = 1'b1;
         end
`else
         romCs = 1'b1;
         ramWe = 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_memory_mapper.sv
// Directed bench for memory_mapper: expectations are queued as each bus
// step is driven and compared once the step's outputs are observable.
module tb_memory_mapper;

   localparam int unsigned AW = 21;

   logic          clock;
   logic          reset;
   logic          cpuCe;
   logic          cpuM1;
   logic          cpuMreq;
   logic          cpuIorq;
   logic          cpuWr;
   logic [7:0]    cpuDi;
   logic [15:0]   cpuA;
   logic          romPage;
   logic          romCs;
   logic          divRomCs;
   logic          divMap;
   logic          vmmPage;
   logic          ramWe;
   logic [AW-1:0] ramA;

   typedef enum int {S_RAMA, S_ROMCS, S_DIVROMCS, S_DIVMAP, S_ROMPAGE, S_VMM, S_RAMWE} sig_e;

   typedef struct {
      string       tag;
      sig_e        sig;
      logic [31:0] value;
   } expect_t;

   expect_t sb[$];
   int      checks = 0;
   int      errors = 0;

   memory_mapper #(.RAMBANKS(8), .DIVPAGES(16), .AW(AW)) dut (
      .clock    (clock),
      .reset    (reset),
      .cpuCe    (cpuCe),
      .cpuM1    (cpuM1),
      .cpuMreq  (cpuMreq),
      .cpuIorq  (cpuIorq),
      .cpuWr    (cpuWr),
      .cpuDi    (cpuDi),
      .cpuA     (cpuA),
      .romPage  (romPage),
      .romCs    (romCs),
      .divRomCs (divRomCs),
      .divMap   (divMap),
      .vmmPage  (vmmPage),
      .ramWe    (ramWe),
      .ramA     (ramA)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] observe(input sig_e s);
      case (s)
         S_RAMA:     return 32'(ramA);
         S_ROMCS:    return 32'(romCs);
         S_DIVROMCS: return 32'(divRomCs);
         S_DIVMAP:   return 32'(divMap);
         S_ROMPAGE:  return 32'(romPage);
         S_VMM:      return 32'(vmmPage);
         default:    return 32'(ramWe);
      endcase
   endfunction

   task automatic want(input string tag, input sig_e s, input logic [31:0] v);
      expect_t e;
      e.tag   = tag;
      e.sig   = s;
      e.value = v;
      sb.push_back(e);
   endtask

   task automatic checkAll();
      expect_t e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sig);
         checks++;
         assert (obs === e.value)
         else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.value);
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic busIdle();
      cpuM1   = 1'b1;
      cpuMreq = 1'b1;
      cpuIorq = 1'b1;
      cpuWr   = 1'b1;
   endtask

   task automatic ioWrite(input logic [15:0] a, input logic [7:0] d);
      cpuA    = a;
      cpuDi   = d;
      cpuIorq = 1'b0;
      cpuWr   = 1'b0;
      tick();
      busIdle();
   endtask

   // Drives a memory cycle and compares all queued expectations during it
   task automatic memAccess(input logic [15:0] a, input logic wr);
      cpuA    = a;
      cpuMreq = 1'b0;
      cpuWr   = ~wr;
      #1;
      checkAll();
      busIdle();
   endtask

   task automatic m1Begin(input logic [15:0] a);
      cpuA    = a;
      cpuM1   = 1'b0;
      cpuMreq = 1'b0;
      tick();
   endtask

   task automatic m1End();
      cpuM1   = 1'b1;
      cpuMreq = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      cpuCe = 1'b1;
      cpuDi = 8'h00;
      cpuA  = 16'h0000;
      busIdle();
      tick();
      tick();
      want("rst_divMap", S_DIVMAP, 0);
      want("rst_romPage", S_ROMPAGE, 0);
      want("rst_vmm", S_VMM, 0);
      want("rst_ramWe", S_RAMWE, 1);
      want("rst_romCs", S_ROMCS, 1);
      checkAll();
      reset = 1'b0;
      tick();

      want("c000_ramA_bank0", S_RAMA, 32'h00000);
      want("c000_romCs", S_ROMCS, 0);
      memAccess(16'hC000, 1'b0);

      ioWrite(16'h7FFD, 8'h17);
      want("c000_ramA_bank7", S_RAMA, 32'h1C000);
      want("romPage_set", S_ROMPAGE, 1);
      want("vmm_clear", S_VMM, 0);
      memAccess(16'hC000, 1'b0);
      want("4000_bank5", S_RAMA, 32'h14123);
      memAccess(16'h4123, 1'b0);
      want("8000_bank2", S_RAMA, 32'h08000);
      memAccess(16'h8000, 1'b0);
      want("rom_write_blocked", S_RAMWE, 1);
      want("rom_cs", S_ROMCS, 1);
      memAccess(16'h0100, 1'b1);
      want("ram_write_passes", S_RAMWE, 0);
      memAccess(16'hC010, 1'b1);

      cpuCe = 1'b0;
      ioWrite(16'h7FFD, 8'h0B);
      cpuCe = 1'b1;
      want("ce_low_no_bank", S_RAMA, 32'h1C000);
      want("ce_low_no_vmm", S_VMM, 0);
      memAccess(16'hC000, 1'b0);

      ioWrite(16'h7FFD, 8'h28);
      ioWrite(16'h7FFD, 8'h07);
      want("locked_bank", S_RAMA, 32'h00000);
      want("locked_vmm", S_VMM, 1);
      want("locked_rom", S_ROMPAGE, 0);
      memAccess(16'hC000, 1'b0);

`ifdef DIVMMC_EN
      m1Begin(16'h0038);
      want("entry_pending_unmapped", S_DIVMAP, 0);
      want("entry_fetch_from_rom", S_ROMCS, 1);
      checkAll();
      m1End();
      want("entry_mapped", S_DIVMAP, 1);
      checkAll();
      want("mapped_divrom", S_DIVROMCS, 1);
      want("mapped_no_rom", S_ROMCS, 0);
      memAccess(16'h0100, 1'b0);
      m1Begin(16'h1FF8);
      want("exit_still_mapped", S_DIVMAP, 1);
      checkAll();
      m1End();
      want("exit_unmapped", S_DIVMAP, 0);
      checkAll();

      m1Begin(16'h3D00);
      want("instant_map", S_DIVMAP, 1);
      checkAll();
      m1End();
      want("instant_divrom", S_DIVROMCS, 1);
      memAccess(16'h0100, 1'b0);

      ioWrite(16'h00E3, 8'h43);
      want("mapram_p3_blocked", S_RAMWE, 1);
      want("mapram_p3_addr", S_RAMA, 32'h46000);
      memAccess(16'h2000, 1'b1);
      ioWrite(16'h00E3, 8'h02);
      want("p2_write_ok", S_RAMWE, 0);
      want("p2_addr", S_RAMA, 32'h44000);
      memAccess(16'h2000, 1'b1);
      want("mapram_sticky_addr", S_RAMA, 32'h46100);
      want("mapram_no_divrom", S_DIVROMCS, 0);
      memAccess(16'h0100, 1'b0);
      want("mapram_low_blocked", S_RAMWE, 1);
      memAccess(16'h0100, 1'b1);
      ioWrite(16'h00E3, 8'h80);
      want("conmem_divrom", S_DIVROMCS, 1);
      memAccess(16'h0100, 1'b0);
      want("conmem_p0_write", S_RAMWE, 0);
      want("conmem_p0_addr", S_RAMA, 32'h40000);
      memAccess(16'h2000, 1'b1);
      ioWrite(16'h00E3, 8'h00);
      m1Begin(16'h1FFC);
      m1End();
      want("exit2_unmapped", S_DIVMAP, 0);
      want("exit2_rom", S_ROMCS, 1);
      want("exit2_no_divrom", S_DIVROMCS, 0);
      memAccess(16'h0100, 1'b0);
      ioWrite(16'h00E3, 8'h80);
      want("conmem_forces_map", S_DIVMAP, 1);
      checkAll();
      ioWrite(16'h00E3, 8'h00);
      want("conmem_off_unmaps", S_DIVMAP, 0);
      checkAll();
`else
      m1Begin(16'h0038);
      m1End();
      want("nodiv_divMap", S_DIVMAP, 0);
      want("nodiv_rom", S_ROMCS, 1);
      want("nodiv_divrom", S_DIVROMCS, 0);
      memAccess(16'h0100, 1'b0);
      ioWrite(16'h00E3, 8'h80);
      want("nodiv_conmem_ignored", S_DIVMAP, 0);
      want("nodiv_rom_2000", S_ROMCS, 1);
      memAccess(16'h2000, 1'b0);
`endif

      m1Begin(16'h0066);
      want("pend_divMap", S_DIVMAP, 0);
      checkAll();
      reset = 1'b1;
      cpuA  = 16'h0100;
      #1;
      want("reset_pend_divMap", S_DIVMAP, 0);
      want("reset_pend_rom", S_ROMCS, 1);
      checkAll();
      tick();
      reset = 1'b0;
      tick();
      m1End();
      want("post_reset_rise_no_map", S_DIVMAP, 0);
      want("post_reset_rom", S_ROMCS, 1);
      want("post_reset_divrom", S_DIVROMCS, 0);
      memAccess(16'h0100, 1'b0);

      ioWrite(16'h7FFD, 8'h05);
      want("lock_cleared_bank5", S_RAMA, 32'h14000);
      memAccess(16'hC000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
